avr_cpu_mul_seq: RTL

Iterative 8×8 multiply sequencer for the AVR core. It implements MUL, MULS, MULSU and, optionally, FMUL, FMULS and FMULSU. It accepts operands from the register-file read ports, runs an 8-step shift-add, and returns a 16-bit product for R1:R0 plus updated C and Z flags. The core pipeline stalls on `busy` and writes back on `done`.

---
 rtl/avr_cpu_mul_seq_if.sv | 24 ++
 rtl/avr_cpu_mul_seq.sv | 128 ++++++++++++
 2 files changed

// File: rtl/avr_cpu_mul_seq_if.sv
// Operand/result bundle between the AVR decode stage and the multiply sequencer.
// The master drives the request and operands; the slave (the sequencer) returns the product.
interface avr_cpu_mul_seq_if;
    logic       start;
    logic [1:0] op;
    logic       frac;
    logic [7:0] d_in;
    logic [7:0] r_in;
    logic [7:0] status_in;
    logic       busy;
    logic       done;
    logic [15:0] result;
    logic [7:0] status_out;

    modport master (
        output start, op, frac, d_in, r_in, status_in,
        input  busy, done, result, status_out
    );

    modport slave (
        input  start, op, frac, d_in, r_in, status_in,
        output busy, done, result, status_out
    );
endinterface

// File: rtl/avr_cpu_mul_seq.sv
// Iterative 8x8 shift-add multiplier for MUL/MULS/MULSU (and FMUL* when AVR_MUL_FRAC_EN is
// defined). Eight RUN cycles, one DONE pulse, registered product and C/Z-updated SREG.
module avr_cpu_mul_seq (
    input logic              clk,
    input logic              reset,
    avr_cpu_mul_seq_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] d_q, d_d;
    logic [7:0]  m_q, m_d;
    logic [15:0] acc_q, acc_d;
    logic [1:0]  op_q, op_d;
    logic [5:0]  sreg_hi_q, sreg_hi_d;
    logic [15:0] result_q, result_d;
    logic [7:0]  status_q, status_d;
`ifdef AVR_MUL_FRAC_EN
    logic        frac_q, frac_d;
`endif

    logic [15:0] addend;
    logic [15:0] prod;
    logic [15:0] res_v;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        d_d       = d_q;
        m_d       = m_q;
        acc_d     = acc_q;
        op_d      = op_q;
        sreg_hi_d = sreg_hi_q;
        result_d  = result_q;
        status_d  = status_q;
`ifdef AVR_MUL_FRAC_EN
        frac_d    = frac_q;
`endif
        addend    = 16'h0000;
        prod      = 16'h0000;
        res_v     = 16'h0000;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d   = StRun;
                    cnt_d     = 3'd0;
                    acc_d     = 16'h0000;
                    m_d       = bus.r_in;
                    op_d      = bus.op;
                    sreg_hi_d = bus.status_in[7:2];
`ifdef AVR_MUL_FRAC_EN
                    frac_d    = bus.frac;
`endif
                    if (bus.op == 2'b01 || bus.op == 2'b10) begin
                        d_d = {{8{bus.d_in[7]}}, bus.d_in};
                    end else begin
                        d_d = {8'h00, bus.d_in};
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                addend = m_q[0] ? d_q : 16'h0000;
                // Under MULS the multiplier's sign bit carries weight -2^7.
                if (cnt_q == 3'd7 && op_q == 2'b01) begin
                    prod = acc_q - addend;
                end else begin
                    prod = acc_q + addend;
                end
                acc_d = prod;
                d_d   = {d_q[14:0], 1'b0};
                m_d   = {1'b0, m_q[7:1]};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = StDone;
`ifdef AVR_MUL_FRAC_EN
                    res_v = frac_q ? {prod[14:0], 1'b0} : prod;
`else
                    res_v = prod;
`endif
                    result_d = res_v;
                    status_d = {sreg_hi_q, (res_v == 16'h0000), prod[15]};
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 3'd0;
            d_q       <= 16'h0000;
            m_q       <= 8'h00;
            acc_q     <= 16'h0000;
            op_q      <= 2'b00;
            sreg_hi_q <= 6'h00;
            result_q  <= 16'h0000;
            status_q  <= 8'h00;
`ifdef AVR_MUL_FRAC_EN
            frac_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            d_q       <= d_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            op_q      <= op_d;
            sreg_hi_q <= sreg_hi_d;
            result_q  <= result_d;
            status_q  <= status_d;
`ifdef AVR_MUL_FRAC_EN
            frac_q    <= frac_d;
`endif
        end
    end

    assign bus.busy       = (state_q == StRun);
    assign bus.done       = (state_q == StDone);
    assign bus.result     = result_q;
    assign bus.status_out = status_q;

endmodule
